// File: rtl/set_bit_enumerator.sv
// Streams the index of every set bit of an accepted vector, LSB-first, one beat
// per cycle, with a running Hamming weight; an all-zero vector yields one empty beat.
module set_bit_enumerator #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_count,
    output logic             out_last,
    output logic             out_empty
);

    if (WIDTH < 2 || WIDTH > 256 || IDX_W != $clog2(WIDTH)) begin : g_bad_params
        $error("set_bit_enumerator: WIDTH must be 2..256 and IDX_W must equal clog2(WIDTH)");
    end

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    localparam logic [WIDTH-1:0] WORK_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   COUNT_ONE = {{IDX_W{1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [IDX_W:0]   count;
    logic [WIDTH-1:0] work_rest;
    logic             accept;
    logic             beat_done;

    // work_rest is work with its lowest set bit cleared; it is zero exactly when
    // at most one bit remains, which makes it the last-beat test as well.
    assign work_rest = work & (work - WORK_ONE);
    assign accept    = in_valid && in_ready;
    assign beat_done = out_valid && out_ready;

    always_comb begin
        out_valid = (state == EMIT);
        out_empty = out_valid && (work == '0);
        out_last  = out_valid && (work_rest == '0);
        out_count = (out_valid && !out_empty) ? count + COUNT_ONE : '0;
        in_ready  = rst_n && ((state == IDLE) || (out_last && out_ready));
        out_idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (work[i]) begin
                out_idx = IDX_W'(i);
            end
        end
    end

    // A new vector accepted on the final beat reloads work directly, so the
    // next vector's first beat follows with no idle bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work  <= in_vec;
                        count <= '0;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (beat_done) begin
                        if (accept) begin
                            work  <= in_vec;
                            count <= '0;
                        end else begin
                            work  <= work_rest;
                            count <= count + COUNT_ONE;
                            if (out_last) begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
